// File: rtl/id_stage_pipe_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pipe_pkg
//   Shared definitions for the LA32R ID stage: datapath width default,
//   register-address width, branch/jump major opcodes and the branch-kind
//   encoding used by the branch unit.
//   No ports (package).
// -----------------------------------------------------------------------------
package id_stage_pipe_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_AW       = 5;

    // Major opcodes, inst[31:26]
    localparam logic [5:0] OP_JIRL = 6'h13;
    localparam logic [5:0] OP_B    = 6'h14;
    localparam logic [5:0] OP_BL   = 6'h15;
    localparam logic [5:0] OP_BEQ  = 6'h16;
    localparam logic [5:0] OP_BNE  = 6'h17;
    localparam logic [5:0] OP_BLT  = 6'h18;
    localparam logic [5:0] OP_BGE  = 6'h19;
    localparam logic [5:0] OP_BLTU = 6'h1a;
    localparam logic [5:0] OP_BGEU = 6'h1b;

    typedef enum logic [3:0] {
        BR_NONE,
        BR_JIRL,
        BR_B,
        BR_BL,
        BR_BEQ,
        BR_BNE,
        BR_BLT,
        BR_BGE,
        BR_BLTU,
        BR_BGEU
    } br_kind_e;

    function automatic br_kind_e decode_br(input logic [5:0] opcode);
        br_kind_e kind;
        case (opcode)
            OP_JIRL: kind = BR_JIRL;
            OP_B:    kind = BR_B;
            OP_BL:   kind = BR_BL;
            OP_BEQ:  kind = BR_BEQ;
            OP_BNE:  kind = BR_BNE;
            OP_BLT:  kind = BR_BLT;
            OP_BGE:  kind = BR_BGE;
            OP_BLTU: kind = BR_BLTU;
            OP_BGEU: kind = BR_BGEU;
            default: kind = BR_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/id_branch_unit.sv
// -----------------------------------------------------------------------------
// id_branch_unit
//   Combinational branch/jump resolution for the ID stage.
//   Ports:
//     opcode  in   6     inst[31:26] of the held instruction
//     pc      in   XLEN  PC of the held instruction
//     opnd1   in   XLEN  forwarded rj value
//     opnd2   in   XLEN  forwarded second-port value (rd for branches)
//     offs    in   26    inst[25:0]; offs16 = offs[25:10], offs26 = {offs[9:0],offs[25:10]}
//     cond    out  1     instruction is a taken branch/jump
//     target  out  XLEN  redirect address (meaningful only when cond=1)
// -----------------------------------------------------------------------------
module id_branch_unit
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [5:0]      opcode,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] opnd1,
    input  logic [XLEN-1:0] opnd2,
    input  logic [25:0]     offs,
    output logic            cond,
    output logic [XLEN-1:0] target
);

    logic [15:0]     offs16;
    logic [25:0]     offs26;
    logic [XLEN-1:0] imm16;
    logic [XLEN-1:0] imm26;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    br_kind_e        kind;

    assign offs16 = offs[25:10];
    assign offs26 = {offs[9:0], offs[25:10]};

    // Word offsets, sign-extended; the adders below wrap modulo 2^XLEN.
    assign imm16 = {{(XLEN-18){offs16[15]}}, offs16, 2'b00};
    assign imm26 = {{(XLEN-28){offs26[25]}}, offs26, 2'b00};

    assign eq   = (opnd1 == opnd2);
    assign lt_s = ($signed(opnd1) < $signed(opnd2));
    assign lt_u = (opnd1 < opnd2);

    assign kind = decode_br(opcode);

    // NOTE: every output gets a default before the case, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        cond   = 1'b0;
        target = pc + imm16;
        case (kind)
            BR_JIRL: begin
                cond   = 1'b1;
                target = opnd1 + imm16;
            end
            BR_B, BR_BL: begin
                cond   = 1'b1;
                target = pc + imm26;
            end
            BR_BEQ:  cond = eq;
            BR_BNE:  cond = !eq;
            BR_BLT:  cond = lt_s;
            BR_BGE:  cond = !lt_s;
            BR_BLTU: cond = lt_u;
            BR_BGEU: cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//   ID pipeline stage of the single-issue LA32R core. Holds one instruction in
//   a valid/allowin register, produces reg-file read addresses, forwards
//   operands from NFWD younger-first sources, stalls on pending results,
//   resolves branches/jumps and counts stall cycles.
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     if_valid/if_pc/if_inst     instruction offered by IF
//     id_allowin                 ID can accept this cycle
//     flush_i                    discard ID contents (later-stage redirect)
//     ex_allowin                 EX can accept this cycle
//     dec_use1/dec_use2          held instruction reads port 1 / port 2
//     dec_rd2_is_rd              port 2 reads rd instead of rk
//     raddr1/raddr2, rdata1/2    reg-file read ports
//     fwd_we/pending/waddr/wdata forwarding sources, index 0 youngest
//     id_valid_o/id_pc/id_inst   transfer to EX
//     opnd1/opnd2                forwarded operands
//     br_taken/br_target         one-cycle redirect pulse and address
//     stall_cnt                  saturating count of stalled valid cycles
// -----------------------------------------------------------------------------
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NFWD  = 3,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid,
    input  logic [XLEN-1:0]        if_pc,
    input  logic [31:0]            if_inst,
    output logic                   id_allowin,
    input  logic                   flush_i,
    input  logic                   ex_allowin,
    input  logic                   dec_use1,
    input  logic                   dec_use2,
    input  logic                   dec_rd2_is_rd,
    output logic [REG_AW-1:0]      raddr1,
    output logic [REG_AW-1:0]      raddr2,
    input  logic [XLEN-1:0]        rdata1,
    input  logic [XLEN-1:0]        rdata2,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD-1:0]        fwd_pending,
    input  logic [NFWD*REG_AW-1:0] fwd_waddr,
    input  logic [NFWD*XLEN-1:0]   fwd_wdata,
    output logic                   id_valid_o,
    output logic [XLEN-1:0]        id_pc,
    output logic [31:0]            id_inst,
    output logic [XLEN-1:0]        opnd1,
    output logic [XLEN-1:0]        opnd2,
    output logic                   br_taken,
    output logic [XLEN-1:0]        br_target,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic            valid_r;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     inst_r;

    logic            pend1;
    logic            pend2;
    logic            stall;
    logic            ready_go;
    logic            br_cond;

    // -------------------------------------------------------------------------
    // Forwarding: scan sources youngest first; the first address match wins,
    // so a ready young result masks a pending older one. r0 always reads 0
    // and never stalls. Result is {pending, data}.
    // -------------------------------------------------------------------------
    function automatic logic [XLEN:0] fwd_pick(
        input logic [REG_AW-1:0]      addr,
        input logic [XLEN-1:0]        rf_data,
        input logic [NFWD-1:0]        we,
        input logic [NFWD-1:0]        pend,
        input logic [NFWD*REG_AW-1:0] waddr,
        input logic [NFWD*XLEN-1:0]   wdata
    );
        logic            hit;
        logic [XLEN:0]   res;
        hit = 1'b0;
        res = {1'b0, rf_data};
        for (int k = 0; k < NFWD; k++) begin
            if (!hit && we[k] && (waddr[REG_AW*k +: REG_AW] == addr)) begin
                hit = 1'b1;
                res = {pend[k], wdata[XLEN*k +: XLEN]};
            end
        end
        if (addr == '0) begin
            res = '0;
        end
        return res;
    endfunction

    assign raddr1 = inst_r[9:5];
    assign raddr2 = dec_rd2_is_rd ? inst_r[4:0] : inst_r[14:10];

    assign {pend1, opnd1} = fwd_pick(raddr1, rdata1, fwd_we, fwd_pending, fwd_waddr, fwd_wdata);
    assign {pend2, opnd2} = fwd_pick(raddr2, rdata2, fwd_we, fwd_pending, fwd_waddr, fwd_wdata);

    // A pending match only matters if the instruction actually reads that port.
    assign stall    = valid_r & ((dec_use1 & pend1) | (dec_use2 & pend2));
    assign ready_go = !stall;

    assign id_allowin = !valid_r | (ready_go & ex_allowin);
    assign id_valid_o = valid_r & ready_go & !flush_i;

    assign id_pc   = pc_r;
    assign id_inst = inst_r;

    // -------------------------------------------------------------------------
    // Branch resolution. A stalled branch cannot fire because id_valid_o
    // carries ready_go; it also waits for EX so the pulse coincides with the
    // branch itself leaving ID.
    // -------------------------------------------------------------------------
    id_branch_unit #(
        .XLEN (XLEN)
    ) u_branch (
        .opcode (inst_r[31:26]),
        .pc     (pc_r),
        .opnd1  (opnd1),
        .opnd2  (opnd2),
        .offs   (inst_r[25:0]),
        .cond   (br_cond),
        .target (br_target)
    );

    assign br_taken = id_valid_o & ex_allowin & br_cond;

    // -------------------------------------------------------------------------
    // Pipeline register. flush dominates; a taken branch squashes the
    // wrong-path instruction IF is offering in the same cycle.
    // NOTE: pc_r/inst_r are reset as well, because id_pc/id_inst are visible
    // outputs that must read zero out of reset, not just valid_r.
    // NOTE: non-blocking assignments throughout, so every register samples
    // the pre-edge value of every other register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
            inst_r  <= '0;
        end else if (flush_i) begin
            valid_r <= 1'b0;
        end else if (br_taken) begin
            valid_r <= 1'b0;
        end else if (id_allowin) begin
            valid_r <= if_valid;
            if (if_valid) begin
                pc_r   <= if_pc;
                inst_r <= if_inst;
            end
        end
    end

    // Stall-cycle counter, saturating; flushed cycles are not stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !flush_i && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
//   Directed bench for id_stage_pipe with a behavioural reference model.
//   The model resolves operands by scanning sources oldest-to-youngest and
//   letting the last (youngest) writer win, and computes branch targets with
//   signed integer arithmetic. A compare process checks the DUT against it on
//   every falling edge; the stimulus adds hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

    localparam int XLEN  = 32;
    localparam int NFWD  = 3;
    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_valid = 1'b0;
    logic [31:0]       if_pc = '0;
    logic [31:0]       if_inst = '0;
    logic              id_allowin;
    logic              flush_i = 1'b0;
    logic              ex_allowin = 1'b0;
    logic              dec_use1 = 1'b0;
    logic              dec_use2 = 1'b0;
    logic              dec_rd2_is_rd = 1'b0;
    logic [4:0]        raddr1;
    logic [4:0]        raddr2;
    logic [31:0]       rdata1 = '0;
    logic [31:0]       rdata2 = '0;
    logic [NFWD-1:0]   fwd_we;
    logic [NFWD-1:0]   fwd_pending;
    logic [NFWD*5-1:0] fwd_waddr;
    logic [NFWD*32-1:0] fwd_wdata;
    logic              id_valid_o;
    logic [31:0]       id_pc;
    logic [31:0]       id_inst;
    logic [31:0]       opnd1;
    logic [31:0]       opnd2;
    logic              br_taken;
    logic [31:0]       br_target;
    logic [CNT_W-1:0]  stall_cnt;

    // Forwarding sources as separate arrays; packed onto the DUT buses below.
    logic        src_we   [NFWD] = '{default: 1'b0};
    logic        src_pend [NFWD] = '{default: 1'b0};
    logic [4:0]  src_addr [NFWD] = '{default: 5'd0};
    logic [31:0] src_data [NFWD] = '{default: 32'd0};

    always_comb begin
        fwd_we      = '0;
        fwd_pending = '0;
        fwd_waddr   = '0;
        fwd_wdata   = '0;
        for (int k = 0; k < NFWD; k++) begin
            fwd_we[k]            = src_we[k];
            fwd_pending[k]       = src_pend[k];
            fwd_waddr[5*k +: 5]  = src_addr[k];
            fwd_wdata[32*k +: 32] = src_data[k];
        end
    end

    id_stage_pipe #(
        .XLEN  (XLEN),
        .NFWD  (NFWD),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .id_allowin    (id_allowin),
        .flush_i       (flush_i),
        .ex_allowin    (ex_allowin),
        .dec_use1      (dec_use1),
        .dec_use2      (dec_use2),
        .dec_rd2_is_rd (dec_rd2_is_rd),
        .raddr1        (raddr1),
        .raddr2        (raddr2),
        .rdata1        (rdata1),
        .rdata2        (rdata2),
        .fwd_we        (fwd_we),
        .fwd_pending   (fwd_pending),
        .fwd_waddr     (fwd_waddr),
        .fwd_wdata     (fwd_wdata),
        .id_valid_o    (id_valid_o),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .opnd1         (opnd1),
        .opnd2         (opnd2),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic        allowin;
        logic        valid_o;
        logic        stall;
        logic        br;
        logic [31:0] target;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
    } exp_t;

    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_inst  = '0;
    logic [31:0] m_cnt   = '0;
    exp_t        m_now;

    // Oldest first, so the youngest matching writer overwrites the result.
    function automatic void resolve(input logic [4:0] a, input logic [31:0] rf,
                                    output logic pend, output logic [31:0] val);
        pend = 1'b0;
        val  = rf;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (src_we[k] && src_addr[k] == a) begin
                pend = src_pend[k];
                val  = src_data[k];
            end
        end
        if (a == 5'd0) begin
            pend = 1'b0;
            val  = 32'd0;
        end
    endfunction

    function automatic exp_t model_eval();
        exp_t               e;
        logic               p1;
        logic               p2;
        logic [31:0]        v1;
        logic [31:0]        v2;
        logic signed [15:0] o16;
        logic signed [25:0] o26;
        int                 off16;
        int                 off26;
        logic               c;
        e     = '0;
        e.ra1 = m_inst[9:5];
        e.ra2 = dec_rd2_is_rd ? m_inst[4:0] : m_inst[14:10];
        resolve(e.ra1, rdata1, p1, v1);
        resolve(e.ra2, rdata2, p2, v2);
        e.op1     = v1;
        e.op2     = v2;
        e.stall   = m_valid && ((dec_use1 && p1) || (dec_use2 && p2));
        e.allowin = !m_valid || (!e.stall && ex_allowin);
        e.valid_o = m_valid && !e.stall && !flush_i;
        o16   = m_inst[25:10];
        o26   = {m_inst[9:0], m_inst[25:10]};
        off16 = int'(o16) * 4;
        off26 = int'(o26) * 4;
        c        = 1'b0;
        e.target = m_pc + 32'(off16);
        case (m_inst[31:26])
            6'h13: begin c = 1'b1; e.target = v1 + 32'(off16); end
            6'h14, 6'h15: begin c = 1'b1; e.target = m_pc + 32'(off26); end
            6'h16: c = (v1 == v2);
            6'h17: c = (v1 != v2);
            6'h18: c = (int'(v1) < int'(v2));
            6'h19: c = (int'(v1) >= int'(v2));
            6'h1a: c = (v1 < v2);
            6'h1b: c = (v1 >= v2);
            default: c = 1'b0;
        endcase
        e.br = e.valid_o && ex_allowin && c;
        return e;
    endfunction

    always_comb m_now = model_eval();

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_inst  <= '0;
            m_cnt   <= '0;
        end else begin
            if (flush_i || m_now.br) begin
                m_valid <= 1'b0;
            end else if (m_now.allowin) begin
                m_valid <= if_valid;
                if (if_valid) begin
                    m_pc   <= if_pc;
                    m_inst <= if_inst;
                end
            end
            if (m_now.stall && !flush_i && m_cnt != 32'hFFFF_FFFF) begin
                m_cnt <= m_cnt + 32'd1;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check_b("cyc_allowin", id_allowin, m_now.allowin);
            check_b("cyc_valid_o", id_valid_o, m_now.valid_o);
            check_b("cyc_br_taken", br_taken, m_now.br);
            check("cyc_id_pc", id_pc, m_pc);
            check("cyc_id_inst", id_inst, m_inst);
            check("cyc_stall_cnt", stall_cnt, m_cnt);
            if (m_valid) begin
                check("cyc_raddr1", 32'(raddr1), 32'(m_now.ra1));
                check("cyc_raddr2", 32'(raddr2), 32'(m_now.ra2));
            end
            if (m_now.br) begin
                check("cyc_br_target", br_target, m_now.target);
            end
            if (m_now.valid_o) begin
                check("cyc_opnd1", opnd1, m_now.op1);
                check("cyc_opnd2", opnd2, m_now.op2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    function automatic logic [31:0] enc_br(input logic [5:0] op, input logic [15:0] offs16,
                                           input logic [4:0] rj, input logic [4:0] rd);
        return {op, offs16, rj, rd};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rj,
                                            input logic [4:0] rk);
        return {17'h00020, rk, rj, rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_srcs();
        for (int k = 0; k < NFWD; k++) begin
            src_we[k]   = 1'b0;
            src_pend[k] = 1'b0;
            src_addr[k] = 5'd0;
            src_data[k] = 32'd0;
        end
    endtask

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check_b("rst_valid_o", id_valid_o, 1'b0);
        check_b("rst_br_taken", br_taken, 1'b0);
        check_b("rst_allowin", id_allowin, 1'b1);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_inst", id_inst, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'd0);

        // beq r4,r5, equal operands, offs16=4
        if_valid      = 1'b1;
        if_pc         = 32'h1C00_0000;
        if_inst       = enc_br(6'h16, 16'd4, 5'd4, 5'd5);
        ex_allowin    = 1'b1;
        dec_use1      = 1'b1;
        dec_use2      = 1'b1;
        dec_rd2_is_rd = 1'b1;
        rdata1        = 32'h10;
        rdata2        = 32'h10;
        tick();
        if_pc   = 32'h1C00_0004;
        if_inst = enc_add(5'd1, 5'd2, 5'd3);
        #1;
        check("beq_raddr1", 32'(raddr1), 32'd4);
        check("beq_raddr2", 32'(raddr2), 32'd5);
        check_b("beq_taken", br_taken, 1'b1);
        check("beq_target", br_target, 32'h1C00_0010);
        tick();
        #1;
        check_b("squash_valid_o", id_valid_o, 1'b0);
        check_b("squash_br", br_taken, 1'b0);
        check_b("squash_allowin", id_allowin, 1'b1);
        check("squash_pc_held", id_pc, 32'h1C00_0000);

        // add r1,r6,r8 with r6 pending in source 0 for two cycles
        if_pc         = 32'h1C00_0100;
        if_inst       = enc_add(5'd1, 5'd6, 5'd8);
        dec_rd2_is_rd = 1'b0;
        rdata1        = 32'h111;
        rdata2        = 32'h222;
        src_we[0]     = 1'b1;
        src_addr[0]   = 5'd6;
        src_pend[0]   = 1'b1;
        src_data[0]   = 32'h1234;
        tick();
        if_pc   = 32'h1C00_0104;
        if_inst = enc_add(5'd2, 5'd7, 5'd9);
        #1;
        check_b("stall1_allowin", id_allowin, 1'b0);
        check_b("stall1_valid_o", id_valid_o, 1'b0);
        tick();
        #1;
        check_b("stall2_allowin", id_allowin, 1'b0);
        check_b("stall2_valid_o", id_valid_o, 1'b0);
        check("stall2_cnt", stall_cnt, 32'd1);
        tick();
        src_pend[0] = 1'b0;
        src_data[0] = 32'hCAFE;
        #1;
        check("stall_done_cnt", stall_cnt, 32'd2);
        check_b("stall_done_valid_o", id_valid_o, 1'b1);
        check("stall_done_opnd1", opnd1, 32'hCAFE);
        check("stall_done_opnd2", opnd2, 32'h222);
        check("stall_done_pc", id_pc, 32'h1C00_0100);

        // add r2,r7,r9: r7 ready in source 0, pending in source 2
        tick();
        src_we[0] = 1'b1; src_addr[0] = 5'd7; src_pend[0] = 1'b0; src_data[0] = 32'hAAAA;
        src_we[2] = 1'b1; src_addr[2] = 5'd7; src_pend[2] = 1'b1; src_data[2] = 32'h5555;
        if_pc   = 32'h1C00_0108;
        if_inst = enc_add(5'd3, 5'd0, 5'd10);
        #1;
        check("young_opnd1", opnd1, 32'hAAAA);
        check_b("young_valid_o", id_valid_o, 1'b1);
        check("young_cnt", stall_cnt, 32'd2);

        // add r3,r0,r10: r0 written (pending) by source 0 must still read 0
        tick();
        src_we[0] = 1'b1; src_addr[0] = 5'd0; src_pend[0] = 1'b1; src_data[0] = 32'hFFFF;
        src_we[2] = 1'b0;
        if_pc   = 32'h1C00_010C;
        if_inst = enc_br(6'h16, 16'd8, 5'd11, 5'd12);
        #1;
        check("r0_opnd1", opnd1, 32'h0);
        check_b("r0_valid_o", id_valid_o, 1'b1);

        // beq r11,r12 stalled on r11, then flushed
        tick();
        dec_rd2_is_rd = 1'b1;
        src_we[0] = 1'b1; src_addr[0] = 5'd11; src_pend[0] = 1'b1;
        flush_i = 1'b1;
        if_pc   = 32'h1C00_0110;
        #1;
        check_b("flush_valid_o", id_valid_o, 1'b0);
        check_b("flush_br", br_taken, 1'b0);
        tick();
        flush_i  = 1'b0;
        if_valid = 1'b0;
        #1;
        check_b("post_flush_allowin", id_allowin, 1'b1);
        check_b("post_flush_valid_o", id_valid_o, 1'b0);
        check("post_flush_cnt", stall_cnt, 32'd2);

        // bltu/bgeu/blt with opnd1=0xFFFFFFFF, opnd2=1
        clear_srcs();
        rdata1   = 32'hFFFF_FFFF;
        rdata2   = 32'h1;
        if_valid = 1'b1;
        if_pc    = 32'h200;
        if_inst  = enc_br(6'h1a, 16'd3, 5'd1, 5'd2);
        tick();
        if_pc   = 32'h204;
        if_inst = enc_br(6'h1b, 16'd3, 5'd1, 5'd2);
        #1;
        check_b("bltu_not_taken", br_taken, 1'b0);
        check_b("bltu_valid_o", id_valid_o, 1'b1);
        tick();
        if_pc   = 32'h208;
        if_inst = enc_br(6'h18, 16'd3, 5'd1, 5'd2);
        #1;
        check_b("bgeu_taken", br_taken, 1'b1);
        check("bgeu_target", br_target, 32'h210);
        tick();
        #1;
        check_b("bgeu_squash", id_valid_o, 1'b0);
        tick();
        if_pc   = 32'h4;
        if_inst = enc_br(6'h16, 16'hFFFC, 5'd1, 5'd2);
        #1;
        check_b("blt_signed_taken", br_taken, 1'b1);
        check("blt_target", br_target, 32'h214);

        // beq backward from pc=4, offs16=-4: wraps to 0xFFFFFFF4
        tick();
        rdata2 = 32'hFFFF_FFFF;
        tick();
        if_pc   = 32'h300;
        if_inst = enc_br(6'h13, 16'h0010, 5'd1, 5'd0);
        #1;
        check_b("back_taken", br_taken, 1'b1);
        check("back_target", br_target, 32'hFFFF_FFF4);

        // jirl r0, r1, 0x10: opnd1 + 0x40 wraps to 0x3F
        tick();
        tick();
        if_pc   = 32'h1000;
        if_inst = {6'h14, 16'h0100, 10'h000};
        #1;
        check_b("jirl_taken", br_taken, 1'b1);
        check("jirl_target", br_target, 32'h3F);

        // b +0x400 with EX not accepting: no redirect until EX allows
        tick();
        tick();
        ex_allowin = 1'b0;
        if_pc      = 32'h2000;
        if_inst    = {6'h15, 16'hFFFF, 10'h3FF};
        #1;
        check_b("b_hold_br", br_taken, 1'b0);
        check_b("b_hold_allowin", id_allowin, 1'b0);
        tick();
        ex_allowin = 1'b1;
        #1;
        check_b("b_taken", br_taken, 1'b1);
        check("b_target", br_target, 32'h1400);
        check("b_pc", id_pc, 32'h1000);

        // bl with offs26=-1: target = pc - 4
        tick();
        tick();
        if_valid = 1'b0;
        #1;
        check_b("bl_taken", br_taken, 1'b1);
        check("bl_target", br_target, 32'h1FFC);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised ID pipeline stage for the single-issue LA32R core.
- Holds one instruction in a valid/allowin pipeline register and generates the register-file read addresses.
- Resolves operand hazards against NFWD forwarding sources and stalls on pending, load-use-style results.
- Resolves branches and jumps in ID and hands forwarded operands plus pc/inst to EX; field decode beyond branches comes from the external sign-produce logic.

Parameters:
XLEN, 32, datapath/PC width
NFWD, 3, number of forwarding sources; index 0 = youngest (EX), higher = older
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
if_valid  in  1  IF presents an instruction
if_pc  in  XLEN  PC of presented instruction
if_inst  in  32  presented instruction
id_allowin  out  1  ID can accept this cycle
flush_i  in  1  discard ID contents (from a later-stage redirect)
ex_allowin  in  1  EX can accept this cycle
dec_use1  in  1  held instruction reads rj (from the external decoder)
dec_use2  in  1  held instruction reads second port
dec_rd2_is_rd  in  1  second read port uses rd instead of rk
raddr1  out  5  reg-file read address 1 (= rj)
raddr2  out  5  reg-file read address 2 (rd or rk)
rdata1  in  XLEN  reg-file data port 1
rdata2  in  XLEN  reg-file data port 2
fwd_we  in  NFWD  source k writes a register
fwd_pending  in  NFWD  source k's data not yet available
fwd_waddr  in  NFWD*5  destination addresses, source k at [5k+4:5k]
fwd_wdata  in  NFWD*XLEN  result data, source k at [XLEN*k+XLEN-1:XLEN*k]
id_valid_o  out  1  ID→EX transfer valid this cycle
id_pc  out  XLEN  held PC
id_inst  out  32  held instruction
opnd1  out  XLEN  forwarded operand 1
opnd2  out  XLEN  forwarded operand 2
br_taken  out  1  redirect pulse
br_target  out  XLEN  redirect address
stall_cnt  out  CNT_W  count of cycles with valid_r & !ready_go

Behaviour:
Pipeline register and handshake
- Registers: valid_r, pc_r, inst_r.
- ready_go = !stall.
- id_allowin = !valid_r | (ready_go & ex_allowin).
- Each clock, in priority order:
  1. !rst_n: all registers cleared; id_valid_o=0, br_taken=0, stall_cnt=0, id_pc=0, id_inst=0.
  2. flush_i: valid_r←0 (dominates the load; an incoming instruction is dropped).
  3. br_taken: valid_r←0 and if_valid is ignored; the wrong-path IF instruction is squashed here, and IF also redirects.
  4. if_valid & id_allowin: load pc_r/inst_r, valid_r←1.
  5. id_allowin & !if_valid: valid_r←0.
  6. otherwise: hold.
- id_valid_o = valid_r & ready_go & !flush_i.
- Latency: instruction accepted in cycle n is offered to EX in cycle n+1 (zero stall).

Forwarding (per port p, address a)
- a==0 → operand 0, no stall.
- Otherwise, search k=0..NFWD-1; the first k with fwd_we[k] & fwd_waddr[k]==a wins.
- Winner pending → stall (only if dec_useP); winner not pending → fwd_wdata[k].
- No match → rdataP.
- Younger source always beats older; a pending older source is masked by a ready younger one.
- stall = valid_r & ((dec_use1 & pend1) | (dec_use2 & pend2)).

Branch resolution
- Decoded from inst_r[31:26]:
  - 0x13 jirl: target = opnd1 + sext(offs16<<2); rd←pc+4 handled downstream.
  - 0x14 b, 0x15 bl: target = pc + sext(offs26<<2); offs26 = {inst[9:0],inst[25:10]}.
  - 0x16 beq, 0x17 bne, 0x18 blt, 0x19 bge (signed), 0x1a bltu, 0x1b bgeu (unsigned), comparing opnd1 vs opnd2: target = pc + sext(offs16<<2).
- All target arithmetic is modulo 2^XLEN (wraps).
- br_taken = valid_r & ready_go & ex_allowin & !flush_i & cond; a one-cycle pulse.
- br_target is valid only when br_taken=1.
- A stalled branch never redirects until its operands are ready.

Stall counter
- Increments when valid_r & !ready_go & !flush_i; saturates at all-ones.

Decomposition:
- Shared package/header: LA32R branch opcode constants, XLEN default, register-address width 5, branch-type encoding.
- Sub-module id_branch_unit: combinational comparison and target adder, taking opcode, pc, opnd1, opnd2, and inst offsets.
- Forwarding mux written as a parametrised for-loop in the top.

Test Plan:
- beq r4,r5 with rdata1=rdata2=0x10, pc=0x1C000000, offs16=4 → br_taken=1 for one cycle, br_target=0x1C000010; next IF instruction squashed (valid_r=0 next cycle).
- add using r6, fwd_we[0]=1, fwd_waddr[0]=6, fwd_pending[0]=1 for 2 cycles → id_allowin=0 and id_valid_o=0 for 2 cycles, stall_cnt=2; cycle 3: id_valid_o=1, opnd1=fwd_wdata[0].
- r7 written by src0 (0xAAAA, ready) and src2 (0x5555, pending) → opnd1=0xAAAA, no stall.
- Stalled instruction with flush_i=1 → valid_r=0 next cycle, id_valid_o=0 the same cycle, no br_taken.
- Read r0 with fwd_waddr[0]=0, fwd_we[0]=1, data 0xFFFF → opnd=0, no stall.
- bltu with opnd1=0xFFFFFFFF, opnd2=1 → not taken; bgeu → taken.
- Backward jump with pc=0x4, offs16=-4 → br_target=0xFFFFFFF4 (wraps).
